sa3x3_ctrl: RTL and testbench



---
 rtl/sa3x3_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sa3x3_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa3x3_ctrl.sv
// Sequencing controller for a 3x3 weight-stationary systolic array: clears the array, loads three
// weight rows, then skews activation vectors in and de-skews bottom-row psums into result words.
module sa3x3_ctrl #(
    parameter int unsigned DW  = 8,
    parameter int unsigned LAT = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      num_vec,
    output logic            busy,
    output logic            done,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [3*DW-1:0] w_data,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [3*DW-1:0] a_data,
    output logic            r_valid,
    output logic [3*DW-1:0] r_data,
    output logic            sa_clear,
    output logic            sa_weight_load,
    output logic [3*DW-1:0] sa_w_in,
    output logic [3*DW-1:0] sa_act_in,
    output logic [3*DW-1:0] sa_psum_in,
    input  logic [3*DW-1:0] sa_psum_out
);

    typedef enum logic [2:0] {StIdle, StClear, StLoadW, StStream, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      nvec_q, nvec_d;
    logic [7:0]      acnt_q, acnt_d;
    logic [1:0]      wcnt_q, wcnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            w_ready_q, w_ready_d;
    logic            a_ready_q, a_ready_d;
    logic            clear_q, clear_d;
    logic [LAT-1:0]  vpipe_q, vpipe_d;
    logic [DW-1:0]   a1_q, a2a_q, a2b_q, a3a_q, a3b_q, a3c_q;
    logic [DW-1:0]   a1_d, a2a_d, a3a_d;
    logic [DW-1:0]   p1a_q, p1b_q, p2a_q;
    logic [3*DW-1:0] r_data_q, r_data_d;
    logic            w_hs, a_hs;

    assign w_hs = w_valid & w_ready_q;
    assign a_hs = a_valid & a_ready_q;

    always_comb begin
        state_d   = state_q;
        nvec_d    = nvec_q;
        acnt_d    = acnt_q;
        wcnt_d    = wcnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        w_ready_d = w_ready_q;
        a_ready_d = a_ready_q;
        clear_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    nvec_d  = num_vec;
                    busy_d  = 1'b1;
                    clear_d = 1'b1;
                end
            end
            StClear: begin
                state_d   = StLoadW;
                w_ready_d = 1'b1;
                wcnt_d    = 2'd0;
            end
            StLoadW: begin
                if (w_hs) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd2) begin
                        w_ready_d = 1'b0;
                        if (nvec_q == 8'd0) begin
                            state_d = StDrain;
                        end else begin
                            state_d   = StStream;
                            a_ready_d = 1'b1;
                            acnt_d    = nvec_q;
                        end
                    end
                end
            end
            StStream: begin
                if (a_hs) begin
                    acnt_d = acnt_q - 8'd1;
                    if (acnt_q == 8'd1) begin
                        a_ready_d = 1'b0;
                        state_d   = StDrain;
                    end
                end
            end
            StDrain: begin
                // Only the final stage may still hold a result; it is presented this cycle.
                if (vpipe_q[LAT-2:0] == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Skew stages load zero on bubble cycles so the array sees clean zeros between vectors.
    always_comb begin
        a1_d     = a_hs ? a_data[DW-1:0]      : '0;
        a2a_d    = a_hs ? a_data[2*DW-1:DW]   : '0;
        a3a_d    = a_hs ? a_data[3*DW-1:2*DW] : '0;
        vpipe_d  = {vpipe_q[LAT-2:0], a_hs};
        r_data_d = {sa_psum_out[3*DW-1:2*DW], p2a_q, p1b_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            nvec_q    <= '0;
            acnt_q    <= '0;
            wcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_ready_q <= 1'b0;
            a_ready_q <= 1'b0;
            clear_q   <= 1'b0;
            vpipe_q   <= '0;
            a1_q      <= '0;
            a2a_q     <= '0;
            a2b_q     <= '0;
            a3a_q     <= '0;
            a3b_q     <= '0;
            a3c_q     <= '0;
            p1a_q     <= '0;
            p1b_q     <= '0;
            p2a_q     <= '0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            nvec_q    <= nvec_d;
            acnt_q    <= acnt_d;
            wcnt_q    <= wcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            w_ready_q <= w_ready_d;
            a_ready_q <= a_ready_d;
            clear_q   <= clear_d;
            vpipe_q   <= vpipe_d;
            a1_q      <= a1_d;
            a2a_q     <= a2a_d;
            a2b_q     <= a2a_q;
            a3a_q     <= a3a_d;
            a3b_q     <= a3a_q;
            a3c_q     <= a3b_q;
            p1a_q     <= sa_psum_out[DW-1:0];
            p1b_q     <= p1a_q;
            p2a_q     <= sa_psum_out[2*DW-1:DW];
            r_data_q  <= r_data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign w_ready        = w_ready_q;
    assign a_ready        = a_ready_q;
    assign r_valid        = vpipe_q[LAT-1];
    assign r_data         = r_data_q;
    assign sa_clear       = clear_q;
    assign sa_weight_load = w_hs;
    assign sa_w_in        = w_hs ? w_data : '0;
    assign sa_act_in      = {a3c_q, a2b_q, a1_q};
    assign sa_psum_in     = '0;

endmodule

// File: tb/tb_sa3x3_ctrl.sv
// Bench for sa3x3_ctrl: behavioural 3x3 array around the DUT, matrix-product reference model,
// table-driven single-vector jobs plus back-to-back, random-gap, empty and mid-job-reset cases.
module tb_sa3x3_ctrl;
    localparam int DW  = 8;
    localparam int LAT = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    num_vec = '0;
    logic          busy, done, w_ready, a_ready, r_valid;
    logic          w_valid = 1'b0;
    logic          a_valid = 1'b0;
    logic [23:0]   w_data = '0;
    logic [23:0]   a_data = '0;
    logic [23:0]   r_data, sa_w_in, sa_act_in, sa_psum_in, sa_psum_out;
    logic          sa_clear, sa_weight_load;

    sa3x3_ctrl #(.DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .r_valid(r_valid), .r_data(r_data),
        .sa_clear(sa_clear), .sa_weight_load(sa_weight_load), .sa_w_in(sa_w_in),
        .sa_act_in(sa_act_in), .sa_psum_in(sa_psum_in), .sa_psum_out(sa_psum_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] p3(input int e1, input int e2, input int e3);
        return {e3[7:0], e2[7:0], e1[7:0]};
    endfunction

    // result column c = sum over rows r of a[r] * W[r][c], mod 256
    function automatic logic [23:0] ref_mac(input logic [23:0] a, input logic [23:0] row1,
                                            input logic [23:0] row2, input logic [23:0] row3);
        logic [23:0] rows [3];
        logic [23:0] res;
        int acc;
        rows[0] = row1;
        rows[1] = row2;
        rows[2] = row3;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            acc = 0;
            for (int r = 0; r < 3; r++) acc += int'(a[r*8 +: 8]) * int'(rows[r][c*8 +: 8]);
            res[c*8 +: 8] = 8'(acc % 256);
        end
        return res;
    endfunction

    // Behavioural array: PE(r,c) registers a_out and psum_out, weights shift down on load.
    logic [7:0] pw [3][3];
    logic [7:0] pa [3][3];
    logic [7:0] pp [3][3];
    always @(posedge clk) begin
        logic [7:0] ai, pin;
        if (sa_clear) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    pw[r][c] <= '0;
                    pa[r][c] <= '0;
                    pp[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    ai  = (c == 0) ? sa_act_in[r*8 +: 8] : pa[r][c-1];
                    pin = (r == 0) ? sa_psum_in[c*8 +: 8] : pp[r-1][c];
                    pa[r][c] <= ai;
                    pp[r][c] <= pin + ai * pw[r][c];
                end
            if (sa_weight_load)
                for (int c = 0; c < 3; c++) begin
                    pw[0][c] <= sa_w_in[c*8 +: 8];
                    pw[1][c] <= pw[0][c];
                    pw[2][c] <= pw[1][c];
                end
        end
    end
    assign sa_psum_out = {pp[2][2], pp[2][1], pp[2][0]};

    // Scoreboard: expected word and due cycle per accepted vector.
    typedef struct {
        logic [23:0] d;
        int          due;
    } exp_t;
    exp_t        exp_q [$];
    exp_t        e;
    logic [23:0] wgot [3];
    int          wcnt_m = 0;
    int          rv_cnt = 0, done_cnt = 0, last_rv_cyc = 0, done_cyc = 0;
    logic [23:0] last_rd = '0;
    logic [23:0] rd_log [$];
    int          rc_log [$];

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            wcnt_m = 0;
        end else begin
            if (sa_clear) wcnt_m = 0;
            if (w_valid && w_ready) begin
                if (wcnt_m < 3) wgot[wcnt_m] = w_data;
                wcnt_m++;
            end
            // first accepted weight row is array row 3, third is row 1
            if (a_valid && a_ready)
                exp_q.push_back('{ref_mac(a_data, wgot[2], wgot[1], wgot[0]), cyc + LAT});
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("r_valid_on_time", {31'd0, r_valid}, 32'd1);
                check("r_data_vs_model", {8'd0, r_data}, {8'd0, e.d});
            end else if (r_valid) begin
                checks++;
                failures++;
                $display("FAIL r_valid_spurious: got r_valid=1 data 0x%0h, expected 0 (cycle %0d)",
                         r_data, cyc);
            end
            if (r_valid) begin
                rv_cnt++;
                last_rv_cyc = cyc;
                last_rd = r_data;
                rd_log.push_back(r_data);
                rc_log.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_w_ready"}, {31'd0, w_ready}, 0);
        check({tag, "_a_ready"}, {31'd0, a_ready}, 0);
        check({tag, "_r_valid"}, {31'd0, r_valid}, 0);
        check({tag, "_r_data"}, {8'd0, r_data}, 0);
        check({tag, "_sa_clear"}, {31'd0, sa_clear}, 0);
        check({tag, "_sa_weight_load"}, {31'd0, sa_weight_load}, 0);
        check({tag, "_sa_w_in"}, {8'd0, sa_w_in}, 0);
        check({tag, "_sa_act_in"}, {8'd0, sa_act_in}, 0);
        check({tag, "_sa_psum_in"}, {8'd0, sa_psum_in}, 0);
    endtask

    logic [23:0] wsend [3];
    logic [23:0] avec [$];

    task automatic run_job(input int nv, input int idle_pct, input int abort_after,
                           input bit spurious_start);
        int  k, guard, rv0, dc0, whs_cyc;
        bit  hs;
        rv0 = rv_cnt;
        dc0 = done_cnt;
        whs_cyc = 0;
        rd_log.delete();
        rc_log.delete();
        start = 1'b1;
        num_vec = nv[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        check("clear_after_start", {31'd0, sa_clear}, 1);
        check("busy_after_start", {31'd0, busy}, 1);
        check("w_ready_low_in_clear", {31'd0, w_ready}, 0);
        @(posedge clk); #1;
        check("w_ready_t2", {31'd0, w_ready}, 1);
        check("sa_clear_one_cycle", {31'd0, sa_clear}, 0);
        if (spurious_start) begin
            start = 1'b1;
            num_vec = 8'd9;
        end
        k = 0;
        guard = 0;
        while (k < 3 && guard < 500) begin
            w_valid = (int'($urandom_range(99)) >= idle_pct);
            w_data = w_valid ? wsend[k] : 24'($urandom);
            #1;
            check("weight_load_strobe", {31'd0, sa_weight_load}, {31'd0, w_valid});
            check("sa_w_in", {8'd0, sa_w_in}, w_valid ? {8'd0, wsend[k]} : 32'd0);
            hs = w_valid && w_ready;
            if (hs && k == 2) whs_cyc = cyc;
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
        end
        w_valid = 1'b0;
        start = 1'b0;
        num_vec = '0;
        check("weight_phase_complete", k, 3);
        check("a_ready_enter", {31'd0, a_ready}, (nv > 0) ? 32'd1 : 32'd0);
        k = 0;
        guard = 0;
        while (k < nv && guard < 2000) begin
            if (abort_after >= 0 && k == abort_after) break;
            a_valid = (int'($urandom_range(99)) >= idle_pct);
            a_data = a_valid ? avec[k] : 24'($urandom);
            hs = a_valid && a_ready;
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
        end
        a_valid = 1'b0;
        if (abort_after >= 0) begin
            #3 rst = 1'b0;
            #1;
            check_all_zero("mid_job_reset");
            @(posedge clk);
            @(posedge clk); #1;
            rst = 1'b1;
            repeat (12) @(posedge clk);
            #1;
            check("abort_no_r_valid", rv_cnt - rv0, 0);
            check("abort_no_done", done_cnt - dc0, 0);
            check("abort_idle", {31'd0, busy}, 0);
            return;
        end
        check("vector_phase_complete", k, nv);
        if (nv > 0) check("a_ready_after_last", {31'd0, a_ready}, 0);
        guard = 0;
        while (!done && guard < 80) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_seen", {31'd0, done}, 1);
        check("busy_in_done", {31'd0, busy}, 1);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 0);
        check("busy_cleared", {31'd0, busy}, 0);
        check("r_valid_count", rv_cnt - rv0, nv);
        check("done_count", done_cnt - dc0, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        if (nv > 0) check("done_after_last_result", done_cyc, last_rv_cyc + 1);
        else check("done_after_empty_load", done_cyc, whs_cyc + 2);
    endtask

    typedef struct {
        logic [23:0] w0, w1, w2;
        logic [23:0] a;
        logic [23:0] r;
    } vec_t;
    localparam int NT = 10;
    vec_t        tbl [NT];
    logic [23:0] exp4 [4];

    initial begin
        // weights listed in send order (w0 lands in array row 3)
        tbl[0] = '{p3(0,0,1), p3(0,1,0), p3(1,0,0), p3(1,2,3), p3(1,2,3)};
        tbl[1] = '{p3(2,2,2), p3(2,2,2), p3(2,2,2), p3(1,2,3), p3(12,12,12)};
        tbl[2] = '{p3(2,2,2), p3(2,2,2), p3(2,2,2), p3(0,0,1), p3(2,2,2)};
        tbl[3] = '{p3(2,2,2), p3(2,2,2), p3(2,2,2), p3(3,3,3), p3(18,18,18)};
        tbl[4] = '{p3(2,2,2), p3(2,2,2), p3(2,2,2), p3(5,0,0), p3(10,10,10)};
        tbl[5] = '{p3(100,100,100), p3(100,100,100), p3(100,100,100), p3(1,1,1), p3(44,44,44)};
        tbl[6] = '{p3(1,2,3), p3(4,5,6), p3(7,8,9), p3(1,0,0), p3(7,8,9)};
        tbl[7] = '{p3(1,2,3), p3(4,5,6), p3(7,8,9), p3(0,0,2), p3(2,4,6)};
        tbl[8] = '{p3(1,2,3), p3(4,5,6), p3(7,8,9), p3(1,1,1), p3(12,15,18)};
        tbl[9] = '{p3(255,255,255), p3(255,255,255), p3(255,255,255), p3(255,255,255),
                   p3(3,3,3)};

        #2 rst = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {31'd0, busy}, 0);

        for (int i = 0; i < NT; i++) begin
            wsend[0] = tbl[i].w0;
            wsend[1] = tbl[i].w1;
            wsend[2] = tbl[i].w2;
            avec.delete();
            avec.push_back(tbl[i].a);
            run_job(1, 0, -1, 1'b0);
            check($sformatf("table_%0d_r_data", i), {8'd0, last_rd}, {8'd0, tbl[i].r});
        end

        // back-to-back vectors give results on consecutive cycles, in order
        for (int i = 0; i < 3; i++) wsend[i] = p3(2, 2, 2);
        avec.delete();
        avec.push_back(p3(1, 2, 3));
        avec.push_back(p3(0, 0, 1));
        avec.push_back(p3(3, 3, 3));
        avec.push_back(p3(5, 0, 0));
        exp4[0] = p3(12, 12, 12);
        exp4[1] = p3(2, 2, 2);
        exp4[2] = p3(18, 18, 18);
        exp4[3] = p3(10, 10, 10);
        run_job(4, 0, -1, 1'b0);
        check("b2b_count", rd_log.size(), 4);
        for (int i = 0; i < rd_log.size() && i < 4; i++)
            check($sformatf("b2b_data_%0d", i), {8'd0, rd_log[i]}, {8'd0, exp4[i]});
        if (rc_log.size() == 4) check("b2b_consecutive", rc_log[3] - rc_log[0], 3);

        // random weights and vectors with heavy stalls on both streams
        for (int i = 0; i < 3; i++) wsend[i] = 24'($urandom);
        avec.delete();
        for (int i = 0; i < 50; i++) avec.push_back(24'($urandom));
        run_job(50, 35, -1, 1'b0);

        // empty job with start held high while busy
        for (int i = 0; i < 3; i++) wsend[i] = 24'($urandom);
        run_job(0, 30, -1, 1'b1);

        // reset during streaming, after three of eight vectors
        for (int i = 0; i < 3; i++) wsend[i] = 24'($urandom);
        avec.delete();
        for (int i = 0; i < 8; i++) avec.push_back(24'($urandom));
        run_job(8, 0, 3, 1'b0);

        // fresh job after the abort: identity weights, results equal inputs
        wsend[0] = p3(0, 0, 1);
        wsend[1] = p3(0, 1, 0);
        wsend[2] = p3(1, 0, 0);
        avec.delete();
        for (int i = 0; i < 3; i++) avec.push_back(24'($urandom));
        run_job(3, 30, -1, 1'b0);
        check("post_abort_identity", {8'd0, last_rd}, {8'd0, avec[2]});

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
